debug_run_controller: RTL and testbench

Sequencer that owns the run/stop behaviour of the MIPS pipeline in debug mode. It sits between the SPI debug command path and the pipeline stages (fetch first). It gates the pipeline enable (`debug_enb`), grants the instruction-RAM write port to the SPI loader (`cs_debug`), issues pipeline reset pulses and single steps, and detects the HALT instruction so the pipeline drains before freezing.

---
 rtl/debug_run_controller_pkg.sv | 24 ++
 rtl/debug_run_controller_sat_counter.sv | 24 ++
 rtl/debug_run_controller.sv | 119 +++++++++++
 tb/tb_debug_run_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/debug_run_controller_pkg.sv
// rtl/debug_run_controller_pkg.sv - command codes, state encodings and opcode constants for the debug run controller
package debug_run_controller_pkg;

    localparam logic [2:0] CMD_NOP      = 3'd0;
    localparam logic [2:0] CMD_LOAD     = 3'd1;
    localparam logic [2:0] CMD_RUN      = 3'd2;
    localparam logic [2:0] CMD_STEP     = 3'd3;
    localparam logic [2:0] CMD_STOP     = 3'd4;
    localparam logic [2:0] CMD_PIPE_RST = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_HALTED = 3'd5,
        ST_PRST   = 3'd6
    } state_t;

    localparam logic [31:0] NOP_OPERATION = 32'h0000_0000;
    localparam logic [31:0] HALT_OPCODE   = 32'hFFFF_FFFF;

endpackage

// File: rtl/debug_run_controller_sat_counter.sv
// rtl/debug_run_controller_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/debug_run_controller.sv
// rtl/debug_run_controller.sv - debug-mode run/stop sequencer for the MIPS pipeline
module debug_run_controller
    import debug_run_controller_pkg::*;
#(
    parameter int                 NB_BITS      = 32,
    parameter int                 NB_CYCLES    = 32,
    parameter logic [NB_BITS-1:0] HALT_OPCODE  = NB_BITS'(debug_run_controller_pkg::HALT_OPCODE),
    parameter int                 DRAIN_CYCLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [2:0]           i_cmd,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic [NB_BITS-1:0]   i_if_instr,
    output logic                 o_debug_enb,
    output logic                 o_cs_debug,
    output logic                 o_pipe_rst,
    output logic                 o_halted,
    output logic [2:0]           o_state,
    output logic [NB_CYCLES-1:0] o_cycle_count
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    state_t          r_state;
    state_t          w_next;
    logic [DW-1:0]   r_drain_cnt;
    logic            r_debug_enb;
    logic            r_cs_debug;
    logic            r_pipe_rst;
    logic            r_halted;
    logic            r_cmd_ready;
    logic            w_acc;
    logic            w_halt;

    assign w_acc  = i_cmd_valid & r_cmd_ready;
    assign w_halt = r_debug_enb & ((r_state == ST_RUN) || (r_state == ST_STEP))
                    & (i_if_instr == HALT_OPCODE);

    // Within RUN, pipeline reset beats a fetched HALT, which beats STOP.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_acc) begin
                    case (i_cmd)
                        CMD_LOAD:     w_next = ST_LOAD;
                        CMD_RUN:      w_next = ST_RUN;
                        CMD_STEP:     w_next = ST_STEP;
                        CMD_PIPE_RST: w_next = ST_PRST;
                        default:      w_next = ST_IDLE;
                    endcase
                end
            end
            ST_LOAD: begin
                if (w_acc && (i_cmd == CMD_STOP))          w_next = ST_IDLE;
                else if (w_acc && (i_cmd == CMD_PIPE_RST)) w_next = ST_PRST;
            end
            ST_RUN: begin
                if (w_acc && (i_cmd == CMD_PIPE_RST))  w_next = ST_PRST;
                else if (w_halt)                       w_next = ST_DRAIN;
                else if (w_acc && (i_cmd == CMD_STOP)) w_next = ST_IDLE;
            end
            ST_STEP:   w_next = w_halt ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: begin
                if (r_drain_cnt == DW'(1)) w_next = ST_HALTED;
            end
            ST_HALTED: begin
                if (w_acc && (i_cmd == CMD_LOAD))          w_next = ST_LOAD;
                else if (w_acc && (i_cmd == CMD_PIPE_RST)) w_next = ST_PRST;
            end
            ST_PRST:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_drain_cnt <= '0;
            r_debug_enb <= 1'b0;
            r_cs_debug  <= 1'b0;
            r_pipe_rst  <= 1'b0;
            r_halted    <= 1'b0;
            r_cmd_ready <= 1'b1;
        end else begin
            r_state <= w_next;
            if ((w_next == ST_DRAIN) && (r_state != ST_DRAIN)) begin
                r_drain_cnt <= DW'(DRAIN_CYCLES);
            end else if (r_state == ST_DRAIN) begin
                r_drain_cnt <= r_drain_cnt - 1'b1;
            end
            r_debug_enb <= (w_next == ST_RUN) || (w_next == ST_STEP) || (w_next == ST_DRAIN);
            r_cs_debug  <= (w_next == ST_LOAD);
            r_pipe_rst  <= (w_next == ST_PRST);
            r_halted    <= (w_next == ST_HALTED);
            r_cmd_ready <= !((w_next == ST_STEP) || (w_next == ST_DRAIN) || (w_next == ST_PRST));
        end
    end

    sat_counter #(
        .WIDTH (NB_CYCLES)
    ) u_cycle_counter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (r_state == ST_PRST),
        .i_en    (r_debug_enb),
        .o_count (o_cycle_count)
    );

    assign o_debug_enb = r_debug_enb;
    assign o_cs_debug  = r_cs_debug;
    assign o_pipe_rst  = r_pipe_rst;
    assign o_halted    = r_halted;
    assign o_cmd_ready = r_cmd_ready;
    assign o_state     = r_state;

endmodule

// File: tb/tb_debug_run_controller.sv
// tb/tb_debug_run_controller.sv - vector table, directed sequences and randomized model checks for debug_run_controller
module tb_debug_run_controller;

    localparam logic [31:0] H = 32'hFFFF_FFFF;
    localparam logic [31:0] N = 32'h0000_0013;
    localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;
    localparam longint MAX4  = 15;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [2:0]  i_cmd;
    logic        i_cmd_valid;
    logic [31:0] i_if_instr;

    logic        a_ready, a_enb, a_cs, a_prst, a_halted;
    logic [2:0]  a_state;
    logic [31:0] a_count;
    logic        b_ready, b_enb, b_cs, b_prst, b_halted;
    logic [2:0]  b_state;
    logic [3:0]  b_count;

    always #5 i_clk = ~i_clk;

    debug_run_controller u_dut (
        .i_clk (i_clk), .i_rst (i_rst), .i_cmd (i_cmd), .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (a_ready), .i_if_instr (i_if_instr), .o_debug_enb (a_enb),
        .o_cs_debug (a_cs), .o_pipe_rst (a_prst), .o_halted (a_halted),
        .o_state (a_state), .o_cycle_count (a_count)
    );

    debug_run_controller #(.NB_CYCLES(4)) u_dut_small (
        .i_clk (i_clk), .i_rst (i_rst), .i_cmd (i_cmd), .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (b_ready), .i_if_instr (i_if_instr), .o_debug_enb (b_enb),
        .o_cs_debug (b_cs), .o_pipe_rst (b_prst), .o_halted (b_halted),
        .o_state (b_state), .o_cycle_count (b_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: state number, cycles of drain still owed, and enabled cycles since last clear.
    int     ms;
    int     mdrain;
    longint mcnt;

    function automatic bit m_ready();
        return !(ms == 3 || ms == 4 || ms == 6);
    endfunction

    function automatic longint sat(input longint c, input longint m);
        return (c > m) ? m : c;
    endfunction

    task automatic model_step(input bit rst, input bit valid, input logic [2:0] cmd, input logic [31:0] instr);
        bit acc, halt, enb;
        int c;
        if (rst) begin
            ms = 0; mdrain = 0; mcnt = 0;
            return;
        end
        acc  = valid && m_ready();
        c    = (cmd > 3'd5) ? 0 : int'(cmd);
        enb  = (ms == 2 || ms == 3 || ms == 4);
        halt = (ms == 2 || ms == 3) && (instr == H);
        if (ms == 6) mcnt = 0;
        else if (enb) mcnt++;
        case (ms)
            0: if (acc) begin
                   if (c == 1) ms = 1;
                   else if (c == 2) ms = 2;
                   else if (c == 3) ms = 3;
                   else if (c == 5) ms = 6;
               end
            1: if (acc && c == 4) ms = 0; else if (acc && c == 5) ms = 6;
            2: if (acc && c == 5) ms = 6;
               else if (halt) begin ms = 4; mdrain = 4; end
               else if (acc && c == 4) ms = 0;
            3: if (halt) begin ms = 4; mdrain = 4; end else ms = 0;
            4: begin mdrain--; if (mdrain == 0) ms = 5; end
            5: if (acc && c == 1) ms = 1; else if (acc && c == 5) ms = 6;
            default: ms = 0;
        endcase
    endtask

    task automatic cyc(input bit rst, input bit valid, input logic [2:0] cmd, input logic [31:0] instr);
        i_rst = rst; i_cmd_valid = valid; i_cmd = cmd; i_if_instr = instr;
        model_step(rst, valid, cmd, instr);
        @(posedge i_clk);
        @(negedge i_clk);
        chk("m_state",  64'(a_state), 64'(ms));
        chk("m_enb",    64'(a_enb),   64'(ms == 2 || ms == 3 || ms == 4));
        chk("m_cs",     64'(a_cs),    64'(ms == 1));
        chk("m_prst",   64'(a_prst),  64'(ms == 6));
        chk("m_halted", 64'(a_halted), 64'(ms == 5));
        chk("m_ready",  64'(a_ready), 64'(m_ready()));
        chk("m_count",  64'(a_count), 64'(sat(mcnt, MAX32)));
        chk("m_count4", 64'(b_count), 64'(sat(mcnt, MAX4)));
        chk("m_excl",   64'(a_cs & a_enb), 64'(0));
    endtask

    typedef struct {
        bit          rst;
        bit          valid;
        logic [2:0]  cmd;
        logic [31:0] instr;
        int          st;
        longint      cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit rst, input bit valid, input logic [2:0] cmd,
                                input logic [31:0] instr, input int st, input longint cnt);
        vec_t v;
        v.rst = rst; v.valid = valid; v.cmd = cmd; v.instr = instr; v.st = st; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    initial begin
        i_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd = 3'd0; i_if_instr = N;
        ms = 0; mdrain = 0; mcnt = 0;

        add(1, 0, 3'd0, N, 0, 0);
        add(0, 1, 3'd1, N, 1, 0);
        add(0, 0, 3'd0, N, 1, 0);
        add(0, 1, 3'd4, N, 0, 0);
        for (int k = 0; k < 3; k++) begin
            add(0, 1, 3'd3, N, 3, k);
            add(0, 1, 3'd2, N, 0, k + 1);
        end
        add(0, 1, 3'd5, N, 6, 3);
        add(0, 0, 3'd0, N, 0, 0);
        add(0, 1, 3'd2, N, 2, 0);
        for (int k = 1; k <= 9; k++) add(0, 0, 3'd0, N, 2, k);
        add(0, 0, 3'd0, H, 4, 10);
        for (int k = 11; k <= 13; k++) add(0, 0, 3'd0, N, 4, k);
        add(0, 0, 3'd0, N, 5, 14);
        add(0, 1, 3'd2, N, 5, 14);
        add(0, 1, 3'd3, N, 5, 14);
        add(0, 1, 3'd5, N, 6, 14);
        add(0, 0, 3'd0, N, 0, 0);
        add(0, 1, 3'd2, N, 2, 0);
        add(0, 0, 3'd0, N, 2, 1);
        add(0, 1, 3'd4, H, 4, 2);
        for (int k = 3; k <= 5; k++) add(0, 0, 3'd0, N, 4, k);
        add(0, 0, 3'd0, N, 5, 6);
        add(0, 1, 3'd5, N, 6, 6);
        add(0, 0, 3'd0, N, 0, 0);
        add(0, 1, 3'd2, N, 2, 0);
        add(0, 1, 3'd5, H, 6, 1);
        add(0, 0, 3'd0, N, 0, 0);
        add(0, 1, 3'd2, N, 2, 0);
        add(0, 0, 3'd0, H, 4, 1);
        add(0, 0, 3'd0, N, 4, 2);
        add(1, 1, 3'd5, N, 0, 0);
        add(0, 0, 3'd0, N, 0, 0);

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].valid, vecs[i].cmd, vecs[i].instr);
            chk($sformatf("v%0d_state", i),  64'(a_state),  64'(vecs[i].st));
            chk($sformatf("v%0d_count", i),  64'(a_count),  64'(vecs[i].cnt));
            chk($sformatf("v%0d_enb", i),    64'(a_enb),    64'(vecs[i].st inside {2, 3, 4}));
            chk($sformatf("v%0d_cs", i),     64'(a_cs),     64'(vecs[i].st == 1));
            chk($sformatf("v%0d_prst", i),   64'(a_prst),   64'(vecs[i].st == 6));
            chk($sformatf("v%0d_halted", i), 64'(a_halted), 64'(vecs[i].st == 5));
            chk($sformatf("v%0d_ready", i),  64'(a_ready),  64'(!(vecs[i].st inside {3, 4, 6})));
        end

        cyc(0, 1, 3'd2, N);
        for (int k = 0; k < 19; k++) cyc(0, 0, 3'd0, N);
        chk("sat_small_hold", 64'(b_count), 64'(15));
        chk("sat_wide_run", 64'(a_count), 64'(19));
        cyc(0, 1, 3'd4, N);
        chk("sat_stop_state", 64'(a_state), 64'(0));
        chk("sat_small_after", 64'(b_count), 64'(15));

        for (int k = 0; k < 2000; k++) begin
            bit          r;
            bit          v;
            logic [2:0]  c;
            logic [31:0] ins;
            r   = ($urandom_range(0, 63) == 0);
            v   = ($urandom_range(0, 1) == 1);
            c   = 3'($urandom_range(0, 7));
            ins = ($urandom_range(0, 7) == 0) ? H : $urandom;
            cyc(r, v, c, ins);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
